// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, op_start/op_clear/op_done handshake.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand goes IDLE -> DONE on the start edge.
module booth_radix4_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 op_signed,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic [2*WIDTH-1:0]   result,
  output logic                 op_done,
  output logic                 busy,
  output logic [1:0]           state
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH+1:0]     mcand_q, mcand_d;
  logic [WIDTH+2:0]     mplr_q,  mplr_d;
  logic [WIDTH+3:0]     acc_q,   acc_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 done_q,  done_d;
  logic                 busy_q,  busy_d;

  logic [WIDTH+3:0]     m_ext_s, m2_s, addend_s, sum_s, acc_sh_s;
  logic [WIDTH+2:0]     mplr_sh_s;
  logic                 cin_s;

  // Booth digit recode, upper-half add and combined 2-bit arithmetic shift
  always_comb begin
    m_ext_s  = {{2{mcand_q[WIDTH+1]}}, mcand_q};
    m2_s     = {m_ext_s[WIDTH+2:0], 1'b0};
    addend_s = {(WIDTH+4){1'b0}};
    cin_s    = 1'b0;
    case (mplr_q[2:0])
      3'b001, 3'b010: addend_s = m_ext_s;
      3'b011:         addend_s = m2_s;
      3'b100:         begin addend_s = ~m2_s;    cin_s = 1'b1; end
      3'b101, 3'b110: begin addend_s = ~m_ext_s; cin_s = 1'b1; end
      default:        addend_s = {(WIDTH+4){1'b0}};
    endcase
    sum_s     = acc_q + addend_s + {{(WIDTH+3){1'b0}}, cin_s};
    // low accumulator bits flow into the vacated top of the multiplier register
    acc_sh_s  = {sum_s[WIDTH+3], sum_s[WIDTH+3], sum_s[WIDTH+3:2]};
    mplr_sh_s = {sum_s[1:0], mplr_q[WIDTH+2:2]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (op_start) begin
          mcand_d = op_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                              : {2'b00, multiplicand};
          mplr_d  = op_signed ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                              : {2'b00, multiplier, 1'b0};
          acc_d   = {(WIDTH+4){1'b0}};
          cnt_d   = CW'(N);
          state_d = S_MUL;
`ifdef MULT_ZERO_SKIP_EN
          if ((multiplier == {WIDTH{1'b0}}) || (multiplicand == {WIDTH{1'b0}})) begin
            cnt_d    = {CW{1'b0}};
            result_d = {(2*WIDTH){1'b0}};
            state_d  = S_DONE;
          end else begin
            state_d  = S_MUL;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d  = acc_sh_s;
        mplr_d = mplr_sh_s;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // product sits one bit above the appended LSB
          result_d = {acc_sh_s[WIDTH-3:0], mplr_sh_s[WIDTH+2:1]};
          state_d  = S_DONE;
        end else begin
          state_d  = S_MUL;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (op_clear) begin
      state_d  = S_IDLE;
      cnt_d    = {CW{1'b0}};
      result_d = {(2*WIDTH){1'b0}};
    end else begin
      cnt_d    = cnt_d;
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_MUL);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= {(WIDTH+2){1'b0}};
      mplr_q   <= {(WIDTH+3){1'b0}};
      acc_q    <= {(WIDTH+4){1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= {(2*WIDTH){1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result  = result_q;
  assign op_done = done_q;
  assign busy    = busy_q;
  assign state   = state_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier: WIDTH=64 corner cases and a WIDTH=8 value sweep.
module tb_booth_radix4_multiplier;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start64 = 1'b0, clear64 = 1'b0, sgn64 = 1'b0;
  logic [63:0]  mr64 = 64'd0, md64 = 64'd0;
  logic [127:0] res64;
  logic         done64, busy64;
  logic [1:0]   st64;

  logic         start8 = 1'b0, clear8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]   mr8 = 8'd0, md8 = 8'd0;
  logic [15:0]  res8;
  logic         done8, busy8;
  logic [1:0]   st8;

  int checks = 0;
  int failures = 0;

  booth_radix4_multiplier #(.WIDTH(64)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .op_start(start64), .op_clear(clear64),
    .op_signed(sgn64), .multiplier(mr64), .multiplicand(md64),
    .result(res64), .op_done(done64), .busy(busy64), .state(st64));

  booth_radix4_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .op_start(start8), .op_clear(clear8),
    .op_signed(sgn8), .multiplier(mr8), .multiplicand(md8),
    .result(res8), .op_done(done8), .busy(busy8), .state(st8));

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // edges counts the start edge as 1; busy_cycles counts post-edge samples with busy=1
  task automatic op64(input logic s, input logic [63:0] mr, input logic [63:0] md,
                      output int edges, output int busy_cycles);
    @(negedge clk);
    sgn64 = s; mr64 = mr; md64 = md; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    edges = 1;
    busy_cycles = busy64 ? 1 : 0;
    while (!done64 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (busy64) busy_cycles++;
    end
    check_eq("done64_reached", {127'd0, done64}, 128'd1);
  endtask

  task automatic clr64();
    @(negedge clk); clear64 = 1'b1;
    @(posedge clk); #1; clear64 = 1'b0;
  endtask

  task automatic op8(input logic s, input logic [7:0] mr, input logic [7:0] md, output int edges);
    @(negedge clk);
    sgn8 = s; mr8 = mr; md8 = md; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 1;
    while (!done8 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int e, b, exp_lat;
    logic [7:0] vals [11];
    logic signed [17:0] p;
    vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h5A, 8'h7F, 8'h80, 8'h81, 8'hA5, 8'hFE, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", {126'd0, st64}, 128'd0);
    check_eq("rst_result", res64, 128'd0);
    check_eq("rst_done_busy", {126'd0, done64, busy64}, 128'd0);
    check_eq("rst_state8", {112'd0, res8 | {14'd0, st8}}, 128'd0);
    @(negedge clk); reset_n = 1'b1;

    op64(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, e, b);
    check_eq("s_m1xm1", res64, 128'd1);
    check_eq("latency64", e, 34);
    check_eq("busy_cycles64", b, 33);
    check_eq("done_state", {126'd0, st64}, 128'd2);
    clr64();
    check_eq("clr_result", res64, 128'd0);
    check_eq("clr_done", {127'd0, done64}, 128'd0);

    op64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, e, b);
    check_eq("u_max_sq", res64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    clr64();
    op64(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, e, b);
    check_eq("s_min_sq", res64, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    clr64();
    op64(1'b1, 64'h8000_0000_0000_0000, 64'd1, e, b);
    check_eq("s_min_x1", res64, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);
    clr64();
    op64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, e, b);
    check_eq("u_max_x2", res64, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);

    // DONE holds against start toggles and operand changes
    @(negedge clk); start64 = 1'b1; mr64 = 64'd5; md64 = 64'd9; sgn64 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("hold_result", res64, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE);
      check_eq("hold_done_state", {125'd0, done64, st64}, 128'h6);
    end
    start64 = 1'b0;
    clr64();

    // abort at step 10 with start on the same edge
    @(negedge clk); sgn64 = 1'b1; mr64 = 64'd11; md64 = 64'd13; start64 = 1'b1;
    @(posedge clk); #1; start64 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); clear64 = 1'b1; start64 = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_state", {126'd0, st64}, 128'd0);
    check_eq("abort_done_busy", {126'd0, done64, busy64}, 128'd0);
    check_eq("abort_result", res64, 128'd0);
    clear64 = 1'b0; start64 = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_start_ignored", {126'd0, st64}, 128'd0);
    op64(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, e, b);
    check_eq("s_7xm3", res64, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
    clr64();

    // clear on the final-step edge wins
    @(negedge clk); sgn64 = 1'b0; mr64 = 64'd3; md64 = 64'd4; start64 = 1'b1;
    @(posedge clk); #1; start64 = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk); clear64 = 1'b1;
    @(posedge clk); #1;
    check_eq("final_clear_state", {126'd0, st64}, 128'd0);
    check_eq("final_clear_done", {127'd0, done64}, 128'd0);
    clear64 = 1'b0;
    @(posedge clk); #1;
    check_eq("final_clear_stays", {126'd0, done64, busy64}, 128'd0);

    // asynchronous reset mid-operation
    @(negedge clk); mr64 = 64'd3; md64 = 64'd4; start64 = 1'b1;
    @(posedge clk); #1; start64 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); reset_n = 1'b0; #1;
    check_eq("midrst_state_busy", {125'd0, st64, busy64}, 128'd0);
    @(negedge clk); reset_n = 1'b1;

    // WIDTH=8 sweep over corner values in both modes
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 11; i++) begin
        for (int j = 0; j < 11; j++) begin
          op8(m[0], vals[i], vals[j], e);
          p = $signed({m[0] & vals[i][7], vals[i]}) * $signed({m[0] & vals[j][7], vals[j]});
          check_eq($sformatf("w8_s%0d_%h_x_%h", m, vals[i], vals[j]), {112'd0, res8}, {112'd0, p[15:0]});
`ifdef MULT_ZERO_SKIP_EN
          exp_lat = (vals[i] == 8'd0 || vals[j] == 8'd0) ? 1 : 6;
`else
          exp_lat = 6;
`endif
          check_eq($sformatf("w8_lat_%h_x_%h", vals[i], vals[j]), e, exp_lat);
          @(negedge clk); clear8 = 1'b1;
          @(posedge clk); #1; clear8 = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
